// File: rtl/fp_sp_pkg.sv
// Shared single-precision constants, field widths and FSM encodings
// for the divider (and the pipelined multiplier).
package fp_sp_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 23;
  localparam int unsigned BIAS      = 127;

  // Working exponent is signed and wide enough for Ea - Eb + BIAS with headroom.
  localparam int unsigned E_W       = 10;
  localparam int unsigned Q_W       = 27;
  localparam int unsigned R_W       = 25;
  localparam int unsigned DIV_STEPS = 27;
  localparam int unsigned CNT_W     = 5;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

  localparam logic signed [E_W-1:0] E_OVF = 10'sd255;
  localparam logic signed [E_W-1:0] E_UNF = 10'sd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_PACK
  } state_t;

  typedef enum logic [2:0] {
    SPC_NONE,
    SPC_NAN,
    SPC_INF,
    SPC_DIVZ,
    SPC_ZERO
  } special_t;

endpackage

// File: rtl/fp_div_sp_if.sv
// Start/done request bus of the single-precision divider.
interface fp_div_sp_if;
  import fp_sp_pkg::*;

  logic              i_START;
  logic [WORD_W-1:0] i_A;
  logic [WORD_W-1:0] i_B;
  logic              o_BUSY;
  logic              o_DONE;
  logic [WORD_W-1:0] o_RES;
  logic              o_INF;
  logic              o_NaN;
  logic              o_ZERO;
  logic              o_DIV_ZERO;
  logic              o_UFLOW;

  modport master (
    output i_START, i_A, i_B,
    input  o_BUSY, o_DONE, o_RES, o_INF, o_NaN, o_ZERO, o_DIV_ZERO, o_UFLOW
  );

  modport slave (
    input  i_START, i_A, i_B,
    output o_BUSY, o_DONE, o_RES, o_INF, o_NaN, o_ZERO, o_DIV_ZERO, o_UFLOW
  );

endinterface

// File: rtl/fp_sp_classify.sv
// Combinational single-precision operand classifier; exponent 0 counts
// as zero so denormals are flushed.
module fp_sp_classify
  import fp_sp_pkg::*;
(
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] frac,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero
);

  always_comb begin
    is_nan  = (&exp) & (|frac);
    is_inf  = (&exp) & ~(|frac);
    is_zero = ~(|exp);
  end

endmodule

// File: rtl/fp_div_sp.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per clock.
// Define FP_DIV_SP_ROUND_EN for round-to-nearest-even; otherwise truncates.
module fp_div_sp
  import fp_sp_pkg::*;
(
  input  logic        i_CLK,
  input  logic        i_RST,
  fp_div_sp_if.slave  bus
);

  logic [WORD_W-1:0]     a;
  logic [WORD_W-1:0]     b;
  logic                  a_nan, a_inf, a_zero;
  logic                  b_nan, b_inf, b_zero;
  state_t                state;
  special_t              spc;
  logic                  sign;
  logic signed [E_W-1:0] e;
  logic [R_W-1:0]        r;
  logic [MANT_W:0]       d;
  logic [Q_W-1:0]        q;
  logic [CNT_W-1:0]      count;
  logic [MANT_W-1:0]     mant;
`ifdef FP_DIV_SP_ROUND_EN
  logic                  guard;
  logic                  sticky;
`endif

  fp_sp_classify u_cls_a (
    .exp     (a[WORD_W-2 -: EXP_W]),
    .frac    (a[MANT_W-1:0]),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .is_zero (a_zero)
  );

  fp_sp_classify u_cls_b (
    .exp     (b[WORD_W-2 -: EXP_W]),
    .frac    (b[MANT_W-1:0]),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .is_zero (b_zero)
  );

  // Biased exponent difference and one restoring-division step.
  logic signed [E_W-1:0] e_init;
  logic                  r_ge;
  logic [R_W-2:0]        r_diff;

  always_comb begin
    e_init = E_W'(a[WORD_W-2 -: EXP_W]) - E_W'(b[WORD_W-2 -: EXP_W]) + E_W'(BIAS);
    r_ge   = (r >= R_W'(d));
    r_diff = (R_W-1)'(r - R_W'(d));
  end

  // Rounding increment; a carry-out leaves the mantissa at zero and bumps E.
  logic                  rnd_up;
  logic                  rnd_carry;
  logic [MANT_W-1:0]     rnd_mant;
  logic signed [E_W-1:0] rnd_exp;

  always_comb begin
`ifdef FP_DIV_SP_ROUND_EN
    rnd_up = guard & (mant[0] | sticky);
`else
    rnd_up = 1'b0;
`endif
    {rnd_carry, rnd_mant} = {1'b0, mant} + (MANT_W+1)'(rnd_up);
    rnd_exp = e + E_W'(rnd_carry);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state          <= S_IDLE;
      spc            <= SPC_NONE;
      a              <= '0;
      b              <= '0;
      sign           <= 1'b0;
      e              <= '0;
      r              <= '0;
      d              <= '0;
      q              <= '0;
      count          <= '0;
      mant           <= '0;
`ifdef FP_DIV_SP_ROUND_EN
      guard          <= 1'b0;
      sticky         <= 1'b0;
`endif
      bus.o_BUSY     <= 1'b0;
      bus.o_DONE     <= 1'b0;
      bus.o_RES      <= '0;
      bus.o_INF      <= 1'b0;
      bus.o_NaN      <= 1'b0;
      bus.o_ZERO     <= 1'b0;
      bus.o_DIV_ZERO <= 1'b0;
      bus.o_UFLOW    <= 1'b0;
    end else begin
      bus.o_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_START) begin
            a          <= bus.i_A;
            b          <= bus.i_B;
            bus.o_BUSY <= 1'b1;
            state      <= S_UNPACK;
          end
        end

        // Special operands skip the divider and go straight to PACK.
        S_UNPACK: begin
          sign  <= a[WORD_W-1] ^ b[WORD_W-1];
          e     <= e_init;
          r     <= R_W'({1'b1, a[MANT_W-1:0]});
          d     <= {1'b1, b[MANT_W-1:0]};
          q     <= '0;
          count <= CNT_W'(DIV_STEPS - 1);
          spc   <= SPC_NONE;
          state <= S_DIVIDE;
          if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spc   <= SPC_NAN;
            state <= S_PACK;
          end else if (a_inf) begin
            spc   <= SPC_INF;
            state <= S_PACK;
          end else if (b_zero) begin
            spc   <= SPC_DIVZ;
            state <= S_PACK;
          end else if (a_zero | b_inf) begin
            spc   <= SPC_ZERO;
            state <= S_PACK;
          end
        end

        S_DIVIDE: begin
          if (r_ge) begin
            q <= {q[Q_W-2:0], 1'b1};
            r <= {r_diff, 1'b0};
          end else begin
            q <= {q[Q_W-2:0], 1'b0};
            r <= {r[R_W-2:0], 1'b0};
          end
          if (count == '0) begin
            state <= S_NORM;
          end else begin
            count <= count - CNT_W'(1);
          end
        end

        // Quotient lies in (0.5, 2): shift by one when the integer bit is clear.
        S_NORM: begin
          if (q[Q_W-1]) begin
            mant   <= q[Q_W-2:3];
`ifdef FP_DIV_SP_ROUND_EN
            guard  <= q[2];
            sticky <= (|q[1:0]) | (|r);
`endif
          end else begin
            mant   <= q[Q_W-3:2];
`ifdef FP_DIV_SP_ROUND_EN
            guard  <= q[1];
            sticky <= q[0] | (|r);
`endif
            e      <= e - E_W'(1);
          end
          state <= S_PACK;
        end

        S_PACK: begin
          bus.o_DONE     <= 1'b1;
          bus.o_BUSY     <= 1'b0;
          bus.o_INF      <= 1'b0;
          bus.o_NaN      <= 1'b0;
          bus.o_ZERO     <= 1'b0;
          bus.o_DIV_ZERO <= 1'b0;
          bus.o_UFLOW    <= 1'b0;
          state          <= S_IDLE;
          case (spc)
            SPC_NAN: begin
              bus.o_RES <= QNAN;
              bus.o_NaN <= 1'b1;
            end
            SPC_INF: begin
              bus.o_RES <= {sign, POS_INF[WORD_W-2:0]};
              bus.o_INF <= 1'b1;
            end
            SPC_DIVZ: begin
              bus.o_RES      <= {sign, POS_INF[WORD_W-2:0]};
              bus.o_INF      <= 1'b1;
              bus.o_DIV_ZERO <= 1'b1;
            end
            SPC_ZERO: begin
              bus.o_RES  <= {sign, (WORD_W-1)'(0)};
              bus.o_ZERO <= 1'b1;
            end
            default: begin
              if (rnd_exp >= E_OVF) begin
                bus.o_RES <= {sign, POS_INF[WORD_W-2:0]};
                bus.o_INF <= 1'b1;
              end else if (rnd_exp <= E_UNF) begin
                bus.o_RES   <= {sign, (WORD_W-1)'(0)};
                bus.o_ZERO  <= 1'b1;
                bus.o_UFLOW <= 1'b1;
              end else begin
                bus.o_RES <= {sign, rnd_exp[EXP_W-1:0], rnd_mant};
              end
            end
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_sp.sv
// Self-checking bench for fp_div_sp: directed corner cases plus random
// operands against an integer-division reference model.
module tb_fp_div_sp;

  logic i_CLK = 1'b0;
  logic i_RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fp_div_sp_if bus ();

  fp_div_sp dut (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .bus   (bus)
  );

  always #5 i_CLK = ~i_CLK;

  // flg = {inf, nan, zero, div_zero, uflow}; spc = short-latency special path
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic        spc;
  } exp_t;

  function automatic exp_t mk(input logic [31:0] res, input logic [4:0] flg, input logic spc);
    exp_t x;
    x.res = res;
    x.flg = flg;
    x.spc = spc;
    return x;
  endfunction

  function automatic logic [4:0] flags_now();
    return {bus.o_INF, bus.o_NaN, bus.o_ZERO, bus.o_DIV_ZERO, bus.o_UFLOW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact quotient via integer division of the 24-bit significands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        an, ai, az, bn, bi, bz, sg;
    longint      num, den, qt;
    int          e, m, sh;
`ifdef FP_DIV_SP_ROUND_EN
    longint      rem;
    logic        g, s;
`endif
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    sg = a[31] ^ b[31];
    an = (ea == 8'hFF) && (fa != 0);
    ai = (ea == 8'hFF) && (fa == 0);
    az = (ea == 8'h00);
    bn = (eb == 8'hFF) && (fb != 0);
    bi = (eb == 8'hFF) && (fb == 0);
    bz = (eb == 8'h00);
    if (an || bn || (az && bz) || (ai && bi)) return mk(32'h7FC00000, 5'b01000, 1'b1);
    if (ai) return mk({sg, 31'h7F800000}, 5'b10000, 1'b1);
    if (bz) return mk({sg, 31'h7F800000}, 5'b10010, 1'b1);
    if (az || bi) return mk({sg, 31'h0}, 5'b00100, 1'b1);
    e   = int'(ea) - int'(eb) + 127;
    num = longint'({1'b1, fa}) << 26;
    den = longint'({1'b1, fb});
    qt  = num / den;
    sh  = (qt >= (longint'(1) << 26)) ? 3 : 2;
    if (sh == 2) e = e - 1;
    m = int'((qt >> sh) & 64'h7FFFFF);
`ifdef FP_DIV_SP_ROUND_EN
    rem = num % den;
    g   = qt[sh-1];
    s   = ((qt & ((longint'(1) << (sh - 1)) - 1)) != 0) || (rem != 0);
    if (g && (m[0] || s)) m = m + 1;
    if (m == (1 << 23)) begin
      m = 0;
      e = e + 1;
    end
`endif
    if (e >= 255) return mk({sg, 31'h7F800000}, 5'b10000, 1'b0);
    if (e <= 0)   return mk({sg, 31'h0}, 5'b00101, 1'b0);
    return mk({sg, 8'(e), 23'(m)}, 5'b00000, 1'b0);
  endfunction

  function automatic logic [31:0] rand_fp(input int mode);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic        sg;
    sg = 1'($urandom_range(0, 1));
    fr = 23'($urandom);
    case (mode)
      0: ex = 8'($urandom_range(100, 154));
      1: return $urandom;
      2: begin
        ex = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
        if ($urandom_range(0, 1) == 0) fr = '0;
      end
      default: ex = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 10))
                                                : 8'($urandom_range(245, 254));
    endcase
    return {sg, ex, fr};
  endfunction

  // Issue one division, wait (bounded) for o_DONE and check everything.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t ex, input string tag);
    int lat;
    lat = 0;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_START = 1'b1;
    @(posedge i_CLK); #1;
    bus.i_START = 1'b0;
    chk({tag, "_busy_hi"}, 32'(bus.o_BUSY), 32'd1);
    do begin
      @(posedge i_CLK); #1;
      lat++;
    end while (!bus.o_DONE && lat < 60);
    chk({tag, "_latency"}, 32'(lat), ex.spc ? 32'd2 : 32'd30);
    chk({tag, "_res"}, bus.o_RES, ex.res);
    chk({tag, "_flags"}, 32'(flags_now()), 32'(ex.flg));
    chk({tag, "_busy_lo"}, 32'(bus.o_BUSY), 32'd0);
  endtask

  initial begin
    int   lat;
    int   ndone;
    logic [31:0] ra, rb;
    bus.i_START = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    repeat (3) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    @(posedge i_CLK); #1;

    chk("reset_res", bus.o_RES, 32'h0);
    chk("reset_flags", 32'(flags_now()), 32'h0);
    chk("reset_busy", 32'(bus.o_BUSY), 32'd0);
    chk("reset_done", 32'(bus.o_DONE), 32'd0);

    // Directed cases, issued back-to-back straight after each o_DONE.
    run_op(32'h40C00000, 32'h40000000, mk(32'h40400000, 5'b00000, 1'b0), "six_by_two");
    run_op(32'hC0C00000, 32'h40000000, mk(32'hC0400000, 5'b00000, 1'b0), "neg_six_by_two");
`ifdef FP_DIV_SP_ROUND_EN
    run_op(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 5'b00000, 1'b0), "one_third");
`else
    run_op(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 5'b00000, 1'b0), "one_third");
`endif
    run_op(32'h3F800000, 32'h00000000, mk(32'h7F800000, 5'b10010, 1'b1), "div_by_zero");
    run_op(32'h00000000, 32'h00000000, mk(32'h7FC00000, 5'b01000, 1'b1), "zero_by_zero");
    run_op(32'h7F000000, 32'h3E800000, mk(32'h7F800000, 5'b10000, 1'b0), "overflow");
    run_op(32'h00800000, 32'h40000000, mk(32'h00000000, 5'b00101, 1'b0), "underflow");
    run_op(32'hFF800000, 32'h40000000, mk(32'hFF800000, 5'b10000, 1'b1), "inf_by_x");
    run_op(32'h40000000, 32'hFF800000, mk(32'h80000000, 5'b00100, 1'b1), "x_by_inf");

    // A second START mid-division must be ignored.
    bus.i_A     = 32'hC0C00000;
    bus.i_B     = 32'h40000000;
    bus.i_START = 1'b1;
    @(posedge i_CLK); #1;
    bus.i_START = 1'b0;
    lat = 0;
    do begin
      @(posedge i_CLK); #1;
      lat++;
      if (lat == 10) begin
        bus.i_A     = 32'h3F800000;
        bus.i_B     = 32'h00000000;
        bus.i_START = 1'b1;
      end
      if (lat == 11) bus.i_START = 1'b0;
    end while (!bus.o_DONE && lat < 60);
    chk("restart_latency", 32'(lat), 32'd30);
    chk("restart_res", bus.o_RES, 32'hC0400000);
    chk("restart_flags", 32'(flags_now()), 32'h0);
    ndone = 0;
    repeat (40) begin
      @(posedge i_CLK); #1;
      if (bus.o_DONE) ndone++;
    end
    chk("restart_extra_done", 32'(ndone), 32'd0);

    // Asynchronous reset in the middle of a division.
    bus.i_A     = 32'h3F800000;
    bus.i_B     = 32'h40400000;
    bus.i_START = 1'b1;
    @(posedge i_CLK); #1;
    bus.i_START = 1'b0;
    repeat (14) begin
      @(posedge i_CLK); #1;
    end
    chk("pre_reset_busy", 32'(bus.o_BUSY), 32'd1);
    i_RST = 1'b1;
    #1;
    chk("mid_reset_res", bus.o_RES, 32'h0);
    chk("mid_reset_busy", 32'(bus.o_BUSY), 32'd0);
    chk("mid_reset_done", 32'(bus.o_DONE), 32'd0);
    chk("mid_reset_flags", 32'(flags_now()), 32'h0);
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge i_CLK); #1;
      if (bus.o_DONE) ndone++;
    end
    chk("post_reset_no_done", 32'(ndone), 32'd0);
    chk("post_reset_busy", 32'(bus.o_BUSY), 32'd0);
    run_op(32'h40C00000, 32'h40000000, mk(32'h40400000, 5'b00000, 1'b0), "after_reset");

    // Random operands against the reference model.
    for (int i = 0; i < 48; i++) begin
      ra = rand_fp($urandom_range(0, 3));
      rb = rand_fp($urandom_range(0, 3));
      run_op(ra, rb, model(ra, rb), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
